cpu_alu_pipe: RTL

- Parametrised two-stage pipelined execute unit: register file plus ALU.
- Accepts decoded ALU instructions over a valid/ready handshake and reads operands with full forwarding.
- Executes ADD/SUB/AND/OR/XOR plus new SLL/SRL/LDI opcodes and retires results with write-back.
- Sits between the decode stage and the retire/commit logic of the CPU.

---
 rtl/cpu_alu_pipe.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/cpu_alu_pipe.sv
// cpu_alu_pipe: two-stage pipelined execute unit (register file + ALU).
//
// Instructions enter through a valid/ready handshake. Operands are resolved at
// acceptance with full forwarding from S1 (live ALU result) and S2 (registered
// result), so dependent instructions may issue back to back. S2 drives the
// out_* interface directly and retiring instructions write back into the
// register file. Register 0 always reads as zero.
//
// Optional feature: define ALU_FLAGS_EN to add out_flags {N,Z,C,V}, registered
// in S2 alongside out_result.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   instruction handshake
//   in_opcode           ADD, SUB, AND, OR, XOR, SLL, SRL, LDI
//   in_rs1/in_rs2/in_rd source and destination register indices
//   in_imm, in_we       immediate (LDI only), write-back enable
//   out_valid/out_ready result handshake
//   out_result/out_rd/out_we  retiring result, destination, write enable
//   out_flags           {N,Z,C,V} (only with ALU_FLAGS_EN)
module cpu_alu_pipe #(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 16,
    localparam int RIDX_W  = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_opcode,
    input  logic [RIDX_W-1:0] in_rs1,
    input  logic [RIDX_W-1:0] in_rs2,
    input  logic [RIDX_W-1:0] in_rd,
    input  logic [WIDTH-1:0]  in_imm,
    input  logic              in_we,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_result,
    output logic [RIDX_W-1:0] out_rd,
`ifdef ALU_FLAGS_EN
    output logic [3:0]        out_flags,
`endif
    output logic              out_we
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_LDI = 3'b111;

    // Stage 1 state
    logic              s1_valid;
    logic [2:0]        s1_op;
    logic [RIDX_W-1:0] s1_rd;
    logic              s1_we;
    logic [WIDTH-1:0]  s1_imm;
    logic [WIDTH-1:0]  s1_a;
    logic [WIDTH-1:0]  s1_b;
    logic [WIDTH-1:0]  s1_result;

    logic [WIDTH-1:0]  regs [NUM_REGS];

    logic              in_fire;
    logic              s1_adv;
    logic              wb_en;
    logic [RIDX_W-1:0] src [2];
    logic [WIDTH-1:0]  opnd [2];

    // in_ready depends only on pipeline state, never on in_valid.
    assign s1_adv   = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || !out_valid || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign wb_en    = out_valid && out_ready && out_we && (out_rd != '0);

    // Operand resolution; S1 is younger than S2, so it wins.
    assign src[0] = in_rs1;
    assign src[1] = in_rs2;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            opnd[i] = regs[src[i]];
            if (src[i] == '0) begin
                opnd[i] = '0;
            end else if (s1_valid && s1_we && (s1_rd == src[i])) begin
                opnd[i] = s1_result;
            end else if (out_valid && out_we && (out_rd == src[i])) begin
                opnd[i] = out_result;
            end
        end
    end

    always_comb begin
        s1_result = '0;
        case (s1_op)
            OP_ADD:  s1_result = s1_a + s1_b;
            OP_SUB:  s1_result = s1_a - s1_b;
            OP_AND:  s1_result = s1_a & s1_b;
            OP_OR:   s1_result = s1_a | s1_b;
            OP_XOR:  s1_result = s1_a ^ s1_b;
            OP_SLL:  s1_result = s1_a << s1_b[SHW-1:0];
            OP_SRL:  s1_result = s1_a >> s1_b[SHW-1:0];
            OP_LDI:  s1_result = s1_imm;
            default: s1_result = '0;
        endcase
    end

`ifdef ALU_FLAGS_EN
    logic [3:0] s1_flags;

    always_comb begin
        s1_flags    = 4'b0000;
        s1_flags[3] = s1_result[WIDTH-1];
        s1_flags[2] = (s1_result == '0);
        if (s1_op == OP_ADD) begin
            // A wrapped sum is smaller than either addend exactly when it carried.
            s1_flags[1] = (s1_result < s1_a);
            s1_flags[0] = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) &&
                          (s1_result[WIDTH-1] != s1_a[WIDTH-1]);
        end else if (s1_op == OP_SUB) begin
            s1_flags[1] = (s1_a >= s1_b);
            s1_flags[0] = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) &&
                          (s1_result[WIDTH-1] != s1_a[WIDTH-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_flags <= 4'b0000;
        end else if (s1_adv) begin
            out_flags <= s1_flags;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= 3'b000;
            s1_rd    <= '0;
            s1_we    <= 1'b0;
            s1_imm   <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_op    <= in_opcode;
            s1_rd    <= in_rd;
            s1_we    <= in_we;
            s1_imm   <= in_imm;
            s1_a     <= opnd[0];
            s1_b     <= opnd[1];
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_rd     <= '0;
            out_we     <= 1'b0;
        end else if (s1_adv) begin
            out_valid  <= 1'b1;
            out_result <= s1_result;
            out_rd     <= s1_rd;
            out_we     <= s1_we;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en) begin
            regs[out_rd] <= out_result;
        end
    end

endmodule
